// File: rtl/lifecycle_controller.sv
// Lifecycle state controller: one authenticated step (or scrap to EOL) per request; signature fetched over sig_rd_en/sig_valid.
// Request-to-done is at least 2 edges; results hold until lc_req drops; requests are ignored during lockout.
module lifecycle_controller #(
    parameter int ID_WIDTH       = 256,
    parameter int NUM_STATES     = 6,
    parameter int STATE_W        = 3,
    parameter int INIT_STATE     = 1,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lc_req,
    input  logic                lc_scrap,
    input  logic [ID_WIDTH-1:0] lc_identifier,
    output logic                sig_rd_en,
    output logic [STATE_W-1:0]  sig_addr,
    input  logic [ID_WIDTH-1:0] sig_rd_data,
    input  logic                sig_valid,
    output logic [STATE_W-1:0]  lc_state,
    output logic                lc_done,
    output logic                lc_success,
    output logic                lc_error,
    output logic                lc_locked,
    output logic [1:0]          lc_fail_count
);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LK_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [STATE_W-1:0] EOL       = STATE_W'(NUM_STATES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LK_W-1:0]    LOCK_LAST = LK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]         FAIL_MAX  = 3'(MAX_FAILS);

    typedef enum logic [1:0] {IDLE, FETCH, DONE, LOCKED} fsm_t;

    fsm_t                fsm, fsm_nxt;
    logic [STATE_W-1:0]  state_nxt;
    logic [ID_WIDTH-1:0] id_reg, id_nxt;
    logic                scrap_reg, scrap_nxt;
    logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
    logic [LK_W-1:0]     lock_cnt, lock_nxt;
    logic [1:0]          fails_nxt, fails_inc;
    logic                done_nxt, success_nxt, error_nxt, locked_nxt, rd_en_nxt;
    logic                pass;

    assign sig_addr  = lc_state;
    assign pass      = (sig_rd_data == id_reg) && (lc_state != EOL);
    assign fails_inc = (lc_fail_count == 2'd3) ? 2'd3 : lc_fail_count + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm           <= IDLE;
            lc_state      <= STATE_W'(INIT_STATE);
            id_reg        <= '0;
            scrap_reg     <= 1'b0;
            tmo_cnt       <= '0;
            lock_cnt      <= '0;
            lc_fail_count <= 2'd0;
            lc_done       <= 1'b0;
            lc_success    <= 1'b0;
            lc_error      <= 1'b0;
            lc_locked     <= 1'b0;
            sig_rd_en     <= 1'b0;
        end else begin
            fsm           <= fsm_nxt;
            lc_state      <= state_nxt;
            id_reg        <= id_nxt;
            scrap_reg     <= scrap_nxt;
            tmo_cnt       <= tmo_nxt;
            lock_cnt      <= lock_nxt;
            lc_fail_count <= fails_nxt;
            lc_done       <= done_nxt;
            lc_success    <= success_nxt;
            lc_error      <= error_nxt;
            lc_locked     <= locked_nxt;
            sig_rd_en     <= rd_en_nxt;
        end
    end

    always_comb begin
        fsm_nxt     = fsm;
        state_nxt   = lc_state;
        id_nxt      = id_reg;
        scrap_nxt   = scrap_reg;
        tmo_nxt     = tmo_cnt;
        lock_nxt    = lock_cnt;
        fails_nxt   = lc_fail_count;
        done_nxt    = lc_done;
        success_nxt = lc_success;
        error_nxt   = lc_error;
        locked_nxt  = lc_locked;
        rd_en_nxt   = sig_rd_en;
        case (fsm)
            IDLE: begin
                if (lc_req) begin
                    id_nxt    = lc_identifier;
                    scrap_nxt = lc_scrap;
                    rd_en_nxt = 1'b1;
                    tmo_nxt   = '0;
                    fsm_nxt   = FETCH;
                end
            end
            FETCH: begin
                // A signature arriving on the expiry edge takes priority over the timeout.
                if (sig_valid) begin
                    done_nxt  = 1'b1;
                    error_nxt = 1'b0;
                    rd_en_nxt = 1'b0;
                    fsm_nxt   = DONE;
                    if (pass) begin
                        state_nxt   = scrap_reg ? EOL : lc_state + STATE_W'(1);
                        success_nxt = 1'b1;
                        fails_nxt   = 2'd0;
                    end else begin
                        success_nxt = 1'b0;
                        id_nxt      = '0;
                        fails_nxt   = fails_inc;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    done_nxt    = 1'b1;
                    success_nxt = 1'b0;
                    error_nxt   = 1'b1;
                    rd_en_nxt   = 1'b0;
                    fails_nxt   = fails_inc;
                    fsm_nxt     = DONE;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            DONE: begin
                if (!lc_req) begin
                    done_nxt    = 1'b0;
                    success_nxt = 1'b0;
                    error_nxt   = 1'b0;
                    if ({1'b0, lc_fail_count} >= FAIL_MAX) begin
                        locked_nxt = 1'b1;
                        lock_nxt   = LOCK_LAST;
                        fsm_nxt    = LOCKED;
                    end else begin
                        fsm_nxt = IDLE;
                    end
                end
            end
            LOCKED: begin
                if (lock_cnt == '0) begin
                    locked_nxt = 1'b0;
                    fails_nxt  = 2'd0;
                    fsm_nxt    = IDLE;
                end else begin
                    lock_nxt = lock_cnt - LK_W'(1);
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end
endmodule
